// File: rtl/qoa_lms_predictor_pkg.sv
// Shared constants for the QOA LMS prediction stage: FSM encodings,
// shift amounts, int16 saturation limits and lms_sel decoding.
package qoa_lms_predictor_pkg;

  typedef logic signed [15:0] s16_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PREDICT = 3'd3;
  localparam logic [2:0] ST_UPDATE  = 3'd4;

  localparam int LMS_SHIFT   = 13;
  localparam int DELTA_SHIFT = 4;

  localparam s16_t INT16_MAX = 16'sh7FFF;
  localparam s16_t INT16_MIN = 16'sh8000;

  // lms_sel[2] picks weights over history; lms_sel[1:0] is the tap index
  localparam int SEL_WEIGHT_BIT = 2;

endpackage

// File: rtl/qoa_clamp16.sv
// Combinational signed saturation of a wide value to int16.
module qoa_clamp16
  import qoa_lms_predictor_pkg::*;
#(
  parameter int IN_W = 35
) (
  input  logic signed [IN_W-1:0] din_i,
  output logic signed [15:0]     dout_o
);

  localparam logic signed [IN_W-1:0] MAX_W = {{(IN_W-16){1'b0}}, INT16_MAX};
  localparam logic signed [IN_W-1:0] MIN_W = {{(IN_W-16){1'b1}}, INT16_MIN};

  always_comb begin
    if (din_i > MAX_W)
      dout_o = INT16_MAX;
    else if (din_i < MIN_W)
      dout_o = INT16_MIN;
    else
      dout_o = din_i[15:0];
  end

endmodule

// File: rtl/qoa_lms_predictor.sv
// QOA LMS predictor: four products through a shared external multiplier,
// residual add with int16 clamp, then LMS weight update and history shift.
//
// state      | meaning
// IDLE       | accept lms_load writes or a start request
// ISSUE      | present history[idx]/weights[idx], pulse mul_start
// WAIT       | hold operands until mul_finished, accumulate product
// PREDICT    | sample <= clamp((acc >>> 13) + residual)
// UPDATE     | valid pulse, weight update, history shift
module qoa_lms_predictor
  import qoa_lms_predictor_pkg::*;
#(
  parameter int ACC_W = 34
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic signed [31:0] residual,
  input  logic               lms_load,
  input  logic [2:0]         lms_sel,
  input  logic signed [15:0] lms_data,
  output logic               busy,
  output logic               valid,
  output logic signed [15:0] sample,
  output logic               mul_start,
  output logic signed [15:0] mul_a,
  output logic signed [15:0] mul_b,
  input  logic signed [31:0] mul_result,
  input  logic               mul_finished
);

  localparam int SUM_W = ACC_W + 1;

  logic [2:0]              state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [31:0]      res_q, res_d;
  s16_t                    sample_q, sample_d;
  s16_t                    hist_q [4];
  s16_t                    hist_d [4];
  s16_t                    wgt_q  [4];
  s16_t                    wgt_d  [4];

  logic signed [SUM_W-1:0] sum;
  s16_t                    clamped;
  s16_t                    delta;
  logic                    op_phase;

  assign sum   = SUM_W'(acc_q >>> LMS_SHIFT) + SUM_W'(res_q);
  assign delta = 16'(res_q >>> DELTA_SHIFT);

  qoa_clamp16 #(.IN_W(SUM_W)) u_clamp (
    .din_i  (sum),
    .dout_o (clamped)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    res_d    = res_q;
    sample_d = sample_q;
    hist_d   = hist_q;
    wgt_d    = wgt_q;
    case (state_q)
      ST_IDLE: begin
        // a coincident load wins and the start request is dropped
        if (lms_load) begin
          if (lms_sel[SEL_WEIGHT_BIT])
            wgt_d[lms_sel[1:0]] = lms_data;
          else
            hist_d[lms_sel[1:0]] = lms_data;
        end else if (start) begin
          res_d   = residual;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_finished) begin
          acc_d   = acc_q + ACC_W'(mul_result);
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? ST_PREDICT : ST_ISSUE;
        end
      end
      ST_PREDICT: begin
        sample_d = clamped;
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        for (int i = 0; i < 4; i++)
          wgt_d[i] = hist_q[i][15] ? (wgt_q[i] - delta) : (wgt_q[i] + delta);
        hist_d[0] = hist_q[1];
        hist_d[1] = hist_q[2];
        hist_d[2] = hist_q[3];
        hist_d[3] = sample_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      sample_q <= '0;
      hist_q   <= '{default: '0};
      wgt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      sample_q <= sample_d;
      hist_q   <= hist_d;
      wgt_q    <= wgt_d;
    end
  end

  // operands come straight from the state arrays, which cannot change in WAIT
  assign op_phase  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mul_a     = op_phase ? hist_q[idx_q] : 16'sd0;
  assign mul_b     = op_phase ? wgt_q[idx_q]  : 16'sd0;
  assign mul_start = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign valid     = (state_q == ST_UPDATE);
  assign sample    = sample_q;

endmodule

// File: doc/qoa_lms_predictor.md
Name: qoa_lms_predictor

Overview:
- Per-sample QOA LMS prediction and reconstruction stage.
- Holds the 4-tap LMS state (history and weights) and computes the prediction sum(history[i]*weights[i]) >> 13 by sequencing four products through the shared 16x16 sequential multiplier, using a start/finished handshake.
- Adds the dequantised residual and clamps the result to int16, then performs the LMS weight update and history shift.
- Sits between the residual dequantiser (upstream) and the sample output buffer (downstream).

Parameters:
- ACC_W, 34, prediction accumulator width (holds four signed 32-bit products without overflow)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to decode one sample
- residual  in  32  signed dequantised residual; sampled on start acceptance
- lms_load  in  1  write one LMS state word
- lms_sel  in  3  0-3 = history[0..3], 4-7 = weights[0..3]
- lms_data  in  16  signed value for lms_load
- busy  out  1  high from start acceptance until the cycle after valid
- valid  out  1  one-cycle pulse: sample is new
- sample  out  16  signed reconstructed sample
- mul_start  out  1  one-cycle pulse to the multiplier
- mul_a  out  16  signed history[i]; held stable until mul_finished
- mul_b  out  16  signed weights[i]; held stable until mul_finished
- mul_result  in  32  signed product
- mul_finished  in  1  one-cycle pulse: mul_result is valid

Behaviour:
- Reset values:
  - Outputs: busy=0, valid=0, sample=0, mul_start=0, mul_a=0, mul_b=0.
  - Internal state: all history and weights = 0, acc=0, idx=0, state=IDLE.
  - Reset mid-operation aborts immediately. No valid is produced. Any in-flight mul_finished after reset is ignored.
- FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | PREDICT) -> UPDATE -> IDLE.
- IDLE:
  - lms_load writes the selected word.
  - start (with no lms_load) latches residual, clears acc and idx, goes to ISSUE; busy=1 from the next cycle.
  - start and lms_load in the same cycle: the load is applied and start is dropped.
- ISSUE: drive mul_a=history[idx], mul_b=weights[idx], pulse mul_start for exactly one cycle, go to WAIT.
- WAIT:
  - mul_a and mul_b stay constant; the multiplier reads operand signs at completion.
  - On mul_finished: acc += sign-extended mul_result; idx++; if idx was 3, go to PREDICT, else go to ISSUE.
- PREDICT:
  - pred = acc >>> 13 (arithmetic shift).
  - s = pred + residual (sign-extended, no overflow).
  - sample <= clamp(s, -32768, 32767).
  - Go to UPDATE.
- UPDATE:
  - valid=1 for one cycle.
  - delta = (residual >>> 4) truncated to 16 bits.
  - For each i: weights[i] += (history[i] < 0) ? -delta : delta, using the old history and 16-bit two's-complement wrap.
  - History shifts: h0<=h1, h1<=h2, h2<=h3, h3<=sample.
  - Go to IDLE; busy=0 in the next cycle.
- Ignored inputs:
  - start and lms_load are ignored while busy.
  - mul_finished outside WAIT is ignored.
- Latency: with multiplier completion latency L cycles after mul_start, valid asserts 4*(L+1)+2 cycles after start acceptance.
- sample holds its value until the next PREDICT; it is not cleared by start.

Decomposition:
- Shared package:
  - state encodings.
  - LMS_SHIFT=13, DELTA_SHIFT=4.
  - INT16_MAX/MIN clamp constants.
  - lms_sel encodings.
- One natural sub-module: qoa_clamp16, combinational signed saturation from wide to 16 bits. It is reused by the output stage.
- The multiplier stays external and is shared through the mul_* handshake.

Test Plan:
- Reset, zero state; start with residual=100:
  - sample=100, one valid pulse.
  - weights all become 6.
  - history = {0,0,0,100}.
  - exactly four mul_start pulses.
- Load weights {0,0,-8192,16384} and history {0,0,100,200}; residual=5:
  - pred=300, sample=305.
  - weights become {0,0,-8192,16384}, all incremented by delta 0.
  - history = {0,100,200,305}.
- History all 32767, weights all 16384; residual=0:
  - acc=2147418112, pred=262136, sample clamps to 32767.
  - Repeat with history all -32768: sample clamps to -32768.
  - Delta negative test: history {-1,1,-1,1}, residual=-32: delta=-2, weights change by {+2,-2,+2,-2}.
- Pulse start and lms_load during WAIT:
  - Both ignored; result identical to the undisturbed run.
  - mul_a and mul_b constant between each mul_start and mul_finished.
- Assert sys_rst_n=0 during the second WAIT, then deliver mul_finished after reset:
  - No valid.
  - All state is zero.
  - The next start produces a correct result.
